// File: rtl/pcie_mwr_initiator.sv
// pcie_mwr_initiator: bus-master write engine for the 64-bit TRN TX link.
// User words are buffered in a FIFO and sent to host memory as 3DW
// Memory Write TLPs. A TLP is split at Max_Payload_Size and never crosses
// a 4 KB boundary, and it only starts once its whole payload is buffered.

module pcie_mwr_initiator #(
  parameter int MAX_PAYLOAD_DW = 32,
  parameter int FIFO_AW        = 6
) (
  input  logic        clk,
  input  logic        trn_reset_n,
  input  logic        start,
  input  logic [31:0] dma_addr,
  input  logic [15:0] dma_len_dw,
  output logic        busy,
  output logic        done,
  input  logic        data_valid,
  input  logic [31:0] data_in,
  output logic        data_ready,
  input  logic [7:0]  cfg_bus_number,
  input  logic [4:0]  cfg_device_number,
  input  logic [2:0]  cfg_function_number,
  input  logic        bus_master_en,
  input  logic        trn_tbuf_av_p,
  output logic [63:0] trn_td,
  output logic [7:0]  trn_trem_n,
  output logic        trn_tsof_n,
  output logic        trn_teof_n,
  output logic        trn_tsrc_rdy_n,
  output logic        trn_tsrc_dsc_n,
  input  logic        trn_tdst_rdy_n
);

  localparam int DEPTH = 2 ** FIFO_AW;

  localparam logic [2:0] ST_IDLE = 3'd0;
  localparam logic [2:0] ST_CALC = 3'd1;
  localparam logic [2:0] ST_WAIT = 3'd2;
  localparam logic [2:0] ST_HDR0 = 3'd3;
  localparam logic [2:0] ST_HDR1 = 3'd4;
  localparam logic [2:0] ST_DATA = 3'd5;
  localparam logic [2:0] ST_FIN  = 3'd6;

  logic [2:0]  state_q, state_d;
  logic [31:0] addr_q, addr_d;
  logic [15:0] remaining_q, remaining_d;
  logic [8:0]  len_q, len_d;
  logic [8:0]  dw_left_q, dw_left_d;
  logic [15:0] req_id_q, req_id_d;
  logic        busy_q, busy_d;

  logic [31:0]        fifo_mem [DEPTH];
  logic [FIFO_AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [FIFO_AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [FIFO_AW:0]   count_q, count_d;
  logic               push;
  logic [1:0]         pop_cnt;
  logic [31:0]        head0;
  logic [31:0]        head1;

  logic        tx_active;
  logic        beat_xfer;
  logic        tlp_end;
  logic        payload_ready;
  logic [8:0]  calc_len;
  logic [31:0] hdr_dw0;
  logic [31:0] hdr_dw1;

  // Host memory is little-endian per DW while the TRN bus is big-endian.
  function automatic logic [31:0] swap32(input logic [31:0] w);
    return {w[7:0], w[15:8], w[23:16], w[31:24]};
  endfunction

  assign data_ready     = (count_q != (FIFO_AW+1)'(DEPTH));
  assign push           = data_valid & data_ready;
  assign head0          = fifo_mem[rd_ptr_q];
  assign head1          = fifo_mem[rd_ptr_q + FIFO_AW'(1)];
  assign tx_active      = (state_q == ST_HDR0) || (state_q == ST_HDR1) || (state_q == ST_DATA);
  assign beat_xfer      = tx_active & ~trn_tdst_rdy_n;
  assign payload_ready  = (32'(count_q) >= 32'(len_q));
  assign busy           = busy_q;
  assign done           = (state_q == ST_FIN);
  assign trn_tsrc_dsc_n = 1'b1;

  assign hdr_dw0 = {1'b0, 2'b10, 5'b00000, 1'b0, 3'b000, 4'b0000, 1'b0, 1'b0,
                    2'b00, 2'b00, 1'b0, len_q};
  assign hdr_dw1 = {req_id_q, 8'h00, (len_q == 9'd1) ? 4'h0 : 4'hF, 4'hF};

  // Payload length of the next TLP: limited by max payload, by what is
  // left of the transfer, and by the distance to the next 4 KB boundary.
  always_comb begin
    logic [10:0] to_boundary;
    logic [16:0] lim;
    to_boundary = 11'd1024 - {1'b0, addr_q[11:2]};
    lim         = 17'(MAX_PAYLOAD_DW);
    if ({1'b0, remaining_q} < lim) lim = {1'b0, remaining_q};
    if ({6'd0, to_boundary} < lim) lim = {6'd0, to_boundary};
    calc_len = lim[8:0];
  end

  // Transfer sequencing: accept a request, size each TLP, gate on buffered
  // payload and link credit, then walk header and data beats.
  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    remaining_d = remaining_q;
    len_d       = len_q;
    dw_left_d   = dw_left_q;
    req_id_d    = req_id_q;
    busy_d      = busy_q;
    tlp_end     = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          addr_d      = dma_addr & 32'hFFFF_FFFC;
          remaining_d = dma_len_dw;
          req_id_d    = {cfg_bus_number, cfg_device_number, cfg_function_number};
          busy_d      = 1'b1;
          state_d     = (dma_len_dw == 16'd0) ? ST_FIN : ST_CALC;
        end
      end
      ST_CALC: begin
        len_d   = calc_len;
        state_d = ST_WAIT;
      end
      ST_WAIT: begin
        if (payload_ready && bus_master_en && trn_tbuf_av_p) state_d = ST_HDR0;
      end
      ST_HDR0: begin
        if (beat_xfer) state_d = ST_HDR1;
      end
      ST_HDR1: begin
        if (beat_xfer) begin
          if (len_q == 9'd1) begin
            tlp_end = 1'b1;
          end else begin
            dw_left_d = len_q - 9'd1;
            state_d   = ST_DATA;
          end
        end
      end
      ST_DATA: begin
        if (beat_xfer) begin
          if (dw_left_q <= 9'd2) tlp_end = 1'b1;
          else dw_left_d = dw_left_q - 9'd2;
        end
      end
      ST_FIN: begin
        busy_d  = 1'b0;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
    if (tlp_end) begin
      addr_d      = addr_q + {21'd0, len_q, 2'b00};
      remaining_d = remaining_q - {7'd0, len_q};
      state_d     = (remaining_q == {7'd0, len_q}) ? ST_FIN : ST_CALC;
    end
  end

  // TX beat formatting; everything is derived from state and FIFO head, so
  // the beat holds steady while the core stalls.
  always_comb begin
    trn_td         = 64'd0;
    trn_trem_n     = 8'h00;
    trn_tsof_n     = 1'b1;
    trn_teof_n     = 1'b1;
    trn_tsrc_rdy_n = 1'b1;
    pop_cnt        = 2'd0;
    case (state_q)
      ST_HDR0: begin
        trn_tsrc_rdy_n = 1'b0;
        trn_tsof_n     = 1'b0;
        trn_td         = {hdr_dw0, hdr_dw1};
      end
      ST_HDR1: begin
        trn_tsrc_rdy_n = 1'b0;
        trn_td         = {addr_q[31:2], 2'b00, swap32(head0)};
        if (len_q == 9'd1) trn_teof_n = 1'b0;
        if (beat_xfer) pop_cnt = 2'd1;
      end
      ST_DATA: begin
        trn_tsrc_rdy_n = 1'b0;
        if (dw_left_q == 9'd1) begin
          trn_td     = {swap32(head0), 32'd0};
          trn_trem_n = 8'h0F;
          trn_teof_n = 1'b0;
          if (beat_xfer) pop_cnt = 2'd1;
        end else begin
          trn_td = {swap32(head0), swap32(head1)};
          if (dw_left_q == 9'd2) trn_teof_n = 1'b0;
          if (beat_xfer) pop_cnt = 2'd2;
        end
      end
      default: ;
    endcase
  end

  // FIFO pointer and occupancy update; push and pop may coincide.
  always_comb begin
    wr_ptr_d = wr_ptr_q + FIFO_AW'(push);
    rd_ptr_d = rd_ptr_q + FIFO_AW'(pop_cnt);
    count_d  = count_q + (FIFO_AW+1)'(push) - (FIFO_AW+1)'(pop_cnt);
  end

  // FIFO storage; contents need no reset since the pointers gate reads.
  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr_q] <= data_in;
  end

  // Control and FIFO pointer registers.
  always_ff @(posedge clk or negedge trn_reset_n) begin
    if (!trn_reset_n) begin
      state_q     <= ST_IDLE;
      addr_q      <= 32'd0;
      remaining_q <= 16'd0;
      len_q       <= 9'd0;
      dw_left_q   <= 9'd0;
      req_id_q    <= 16'd0;
      busy_q      <= 1'b0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      remaining_q <= remaining_d;
      len_q       <= len_d;
      dw_left_q   <= dw_left_d;
      req_id_q    <= req_id_d;
      busy_q      <= busy_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
    end
  end

endmodule

// File: tb/tb_pcie_mwr_initiator.sv
// Scoreboard bench for pcie_mwr_initiator: stimulus pushes expected TX beats,
// a monitor pops and compares them on every accepted beat.

module tb_pcie_mwr_initiator;

  localparam int MAXP = 32;

  logic        clk = 1'b0;
  logic        trn_reset_n;
  logic        start;
  logic [31:0] dma_addr;
  logic [15:0] dma_len_dw;
  logic        busy;
  logic        done;
  logic        data_valid;
  logic [31:0] data_in;
  logic        data_ready;
  logic [7:0]  cfg_bus_number;
  logic [4:0]  cfg_device_number;
  logic [2:0]  cfg_function_number;
  logic        bus_master_en;
  logic        trn_tbuf_av_p;
  logic [63:0] trn_td;
  logic [7:0]  trn_trem_n;
  logic        trn_tsof_n;
  logic        trn_teof_n;
  logic        trn_tsrc_rdy_n;
  logic        trn_tsrc_dsc_n;
  logic        trn_tdst_rdy_n;

  typedef struct packed {
    logic [63:0] td;
    logic [7:0]  trem;
    logic        sof;
    logic        eof;
  } beat_t;

  beat_t       exp_q[$];
  logic [31:0] feed_q[$];
  logic [31:0] model_q[$];

  int check_count = 0;
  int pass_count  = 0;
  int done_count  = 0;
  int cyc         = 0;
  int first_sof_cycle = -1;
  int start_cycle = 0;

  logic        held = 1'b0;
  logic [63:0] held_td;
  logic [63:0] held_ctl;

  pcie_mwr_initiator #(.MAX_PAYLOAD_DW(MAXP), .FIFO_AW(6)) dut (
    .clk(clk), .trn_reset_n(trn_reset_n), .start(start), .dma_addr(dma_addr),
    .dma_len_dw(dma_len_dw), .busy(busy), .done(done), .data_valid(data_valid),
    .data_in(data_in), .data_ready(data_ready), .cfg_bus_number(cfg_bus_number),
    .cfg_device_number(cfg_device_number), .cfg_function_number(cfg_function_number),
    .bus_master_en(bus_master_en), .trn_tbuf_av_p(trn_tbuf_av_p), .trn_td(trn_td),
    .trn_trem_n(trn_trem_n), .trn_tsof_n(trn_tsof_n), .trn_teof_n(trn_teof_n),
    .trn_tsrc_rdy_n(trn_tsrc_rdy_n), .trn_tsrc_dsc_n(trn_tsrc_dsc_n),
    .trn_tdst_rdy_n(trn_tdst_rdy_n)
  );

  always #5 clk = ~clk;

  // Cycle counter used for latency measurement.
  always @(posedge clk) cyc++;

  function automatic logic [31:0] bswap(input logic [31:0] w);
    return {w[7:0], w[15:8], w[23:16], w[31:24]};
  endfunction

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    check_count++;
    if (act !== exp) $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
    else pass_count++;
  endtask

  // Feeds user words from feed_q into the FIFO whenever it has room.
  initial begin
    data_valid = 1'b0;
    data_in    = 32'd0;
    forever begin
      @(posedge clk); #1;
      if (feed_q.size() > 0) begin
        data_valid = 1'b1;
        data_in    = feed_q[0];
      end else begin
        data_valid = 1'b0;
        data_in    = 32'd0;
      end
      @(negedge clk);
      if (data_valid && data_ready && trn_reset_n && feed_q.size() > 0) void'(feed_q.pop_front());
    end
  end

  // Monitor: compares accepted beats against the scoreboard and checks that
  // a stalled beat does not change.
  always @(negedge clk) begin
    if (!trn_reset_n) begin
      held = 1'b0;
    end else begin
      if (done) done_count++;
      if (!trn_tsrc_rdy_n) begin
        if (held) begin
          checkOutput("hold_td", trn_td, held_td);
          checkOutput("hold_ctl", {54'd0, trn_trem_n, trn_tsof_n, trn_teof_n}, held_ctl);
        end
        if (!trn_tsof_n && first_sof_cycle < 0) first_sof_cycle = cyc;
        if (!trn_tdst_rdy_n) begin
          held = 1'b0;
          if (exp_q.size() == 0) begin
            check_count++;
            $display("[TB] FAIL sb_unexpected: got beat td=%h, expected no beat", trn_td);
          end else begin
            beat_t e;
            e = exp_q.pop_front();
            checkOutput("sb_td", trn_td, e.td);
            checkOutput("sb_ctl", {54'd0, trn_trem_n, trn_tsof_n, trn_teof_n},
                        {54'd0, e.trem, e.sof, e.eof});
          end
        end else begin
          held     = 1'b1;
          held_td  = trn_td;
          held_ctl = {54'd0, trn_trem_n, trn_tsof_n, trn_teof_n};
        end
      end else begin
        held = 1'b0;
      end
    end
  end

  task automatic expectBeat(input logic [63:0] td, input logic [7:0] trem, input logic sof, input logic eof);
    beat_t b;
    b.td = td; b.trem = trem; b.sof = sof; b.eof = eof;
    exp_q.push_back(b);
  endtask

  task automatic feedWord(input logic [31:0] w);
    feed_q.push_back(w);
  endtask

  task automatic feedModelWords(input int n, input logic [31:0] base);
    for (int i = 0; i < n; i++) begin
      feed_q.push_back(base + 32'(i) * 32'h0101_0103);
      model_q.push_back(base + 32'(i) * 32'h0101_0103);
    end
  endtask

  // Reference TLP builder: splits the transfer and lays the DW stream onto
  // 64-bit beats, consuming payload words from model_q.
  task automatic expectTransfer(input logic [31:0] addr, input int len, input logic [15:0] id);
    logic [31:0] a;
    logic [31:0] dws[$];
    int rem, bnd, l, nb;
    logic odd;
    a   = {addr[31:2], 2'b00};
    rem = len;
    while (rem > 0) begin
      bnd = (4096 - int'(a[11:0])) / 4;
      l   = MAXP;
      if (rem < l) l = rem;
      if (bnd < l) l = bnd;
      dws.delete();
      dws.push_back(32'h4000_0000 | 32'(l));
      dws.push_back({id, 8'h00, (l == 1) ? 4'h0 : 4'hF, 4'hF});
      dws.push_back(a);
      for (int i = 0; i < l; i++) dws.push_back(bswap(model_q.pop_front()));
      odd = (dws.size() % 2) == 1;
      if (odd) dws.push_back(32'd0);
      nb = dws.size() / 2;
      for (int b = 0; b < nb; b++)
        expectBeat({dws[2*b], dws[2*b+1]}, (b == nb-1 && odd) ? 8'h0F : 8'h00,
                   (b == 0) ? 1'b0 : 1'b1, (b == nb-1) ? 1'b0 : 1'b1);
      a   = a + 32'(4 * l);
      rem = rem - l;
    end
  endtask

  task automatic applyStimulus(input logic [31:0] addr, input logic [15:0] len);
    @(posedge clk); #1;
    dma_addr        = addr;
    dma_len_dw      = len;
    start           = 1'b1;
    start_cycle     = cyc;
    first_sof_cycle = -1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic waitIdle(input string name, input int budget);
    int n;
    n = 0;
    while (busy !== 1'b0 && n < budget) begin
      @(negedge clk);
      n++;
    end
    checkOutput({name, "_in_time"}, 64'(n < budget), 64'd1);
    @(posedge clk); #1;
  endtask

  task automatic endOfTransfer(input string name, input int budget, input int done_before);
    waitIdle(name, budget);
    checkOutput({name, "_done_pulses"}, 64'(done_count - done_before), 64'd1);
    checkOutput({name, "_sb_empty"}, 64'(exp_q.size()), 64'd0);
  endtask

  initial begin
    int d0, n;
    trn_reset_n         = 1'b0;
    start               = 1'b0;
    dma_addr            = 32'd0;
    dma_len_dw          = 16'd0;
    cfg_bus_number      = 8'h01;
    cfg_device_number   = 5'd1;
    cfg_function_number = 3'd0;
    bus_master_en       = 1'b1;
    trn_tbuf_av_p       = 1'b1;
    trn_tdst_rdy_n      = 1'b0;
    repeat (3) @(posedge clk);
    #1 trn_reset_n = 1'b1;

    // Reset state
    @(negedge clk);
    checkOutput("rst_busy", 64'(busy), 64'd0);
    checkOutput("rst_done", 64'(done), 64'd0);
    checkOutput("rst_srdy", 64'(trn_tsrc_rdy_n), 64'd1);
    checkOutput("rst_sof_eof", {62'd0, trn_tsof_n, trn_teof_n}, 64'd3);
    checkOutput("rst_trem", 64'(trn_trem_n), 64'd0);
    checkOutput("rst_td", trn_td, 64'd0);
    checkOutput("rst_ready", 64'(data_ready), 64'd1);
    checkOutput("rst_dsc", 64'(trn_tsrc_dsc_n), 64'd1);

    // Single DW, with data already buffered
    $display("[TB] single DW");
    feedWord(32'h1122_3344);
    repeat (4) @(posedge clk);
    expectBeat(64'h4000_0001_0108_000F, 8'h00, 1'b0, 1'b1);
    expectBeat(64'h1000_0000_4433_2211, 8'h00, 1'b1, 1'b0);
    d0 = done_count;
    applyStimulus(32'h1000_0000, 16'd1);
    endOfTransfer("single", 50, d0);
    checkOutput("single_latency", 64'(first_sof_cycle - start_cycle), 64'd3);

    // Two DW, odd DW count ends with a half beat
    $display("[TB] two DW");
    feedWord(32'h0000_000A);
    feedWord(32'h0000_000B);
    expectBeat(64'h4000_0002_0108_00FF, 8'h00, 1'b0, 1'b1);
    expectBeat(64'h2000_0004_0A00_0000, 8'h00, 1'b1, 1'b1);
    expectBeat(64'h0B00_0000_0000_0000, 8'h0F, 1'b1, 1'b0);
    d0 = done_count;
    applyStimulus(32'h2000_0004, 16'd2);
    endOfTransfer("two", 50, d0);

    // 4 KB boundary split: 0xFF0 len 8 -> 4 DW at 0xFF0, 4 DW at 0x1000
    $display("[TB] 4KB split");
    feedModelWords(8, 32'hA000_0001);
    expectTransfer(32'h0000_0FF0, 8, 16'h0108);
    d0 = done_count;
    applyStimulus(32'h0000_0FF0, 16'd8);
    endOfTransfer("split4k", 100, d0);

    // Max payload split: 70 DW -> 32, 32, 6; feeder refills during transfer
    $display("[TB] max payload split");
    feedModelWords(70, 32'hB000_0010);
    expectTransfer(32'h0001_0000, 70, 16'h0108);
    d0 = done_count;
    applyStimulus(32'h0001_0000, 16'd70);
    endOfTransfer("mps", 1000, d0);

    // Start while busy is ignored; one word left over for later
    $display("[TB] start while busy");
    trn_tbuf_av_p = 1'b0;
    feedModelWords(5, 32'hC000_0100);
    expectTransfer(32'h5000_0000, 4, 16'h0108);
    d0 = done_count;
    applyStimulus(32'h5000_0000, 16'd4);
    repeat (3) @(posedge clk);
    applyStimulus(32'h6000_0000, 16'd3);
    checkOutput("busy_held", 64'(busy), 64'd1);
    @(posedge clk); #1;
    trn_tbuf_av_p = 1'b1;
    endOfTransfer("ignore_start", 100, d0);

    // Zero length: done one cycle after the start cycle, no beats
    $display("[TB] zero length");
    d0 = done_count;
    applyStimulus(32'h7000_0000, 16'd0);
    @(negedge clk);
    checkOutput("len0_done", 64'(done), 64'd1);
    checkOutput("len0_srdy", 64'(trn_tsrc_rdy_n), 64'd1);
    @(negedge clk);
    checkOutput("len0_done_once", 64'(done), 64'd0);
    checkOutput("len0_busy", 64'(busy), 64'd0);
    @(posedge clk); #1;
    checkOutput("len0_pulses", 64'(done_count - d0), 64'd1);

    // Backpressure and gating; leftover word is the first payload word
    $display("[TB] backpressure");
    bus_master_en = 1'b0;
    feedModelWords(9, 32'hD000_0200);
    expectTransfer(32'h3000_0000, 10, 16'h0108);
    d0 = done_count;
    applyStimulus(32'h3000_0000, 16'd10);
    repeat (10) begin
      @(negedge clk);
      checkOutput("gate_bme", 64'(trn_tsrc_rdy_n), 64'd1);
    end
    @(posedge clk); #1;
    bus_master_en = 1'b1;
    trn_tbuf_av_p = 1'b0;
    repeat (20) begin
      @(negedge clk);
      checkOutput("gate_tbuf", 64'(trn_tsrc_rdy_n), 64'd1);
    end
    @(posedge clk); #1;
    trn_tbuf_av_p = 1'b1;
    n = 0;
    while (busy && n < 400) begin
      @(posedge clk); #1;
      trn_tdst_rdy_n = 1'($urandom_range(0, 1));
      n++;
    end
    trn_tdst_rdy_n = 1'b0;
    checkOutput("bp_in_time", 64'(n < 400), 64'd1);
    @(posedge clk); #1;
    checkOutput("bp_done_pulses", 64'(done_count - d0), 64'd1);
    checkOutput("bp_sb_empty", 64'(exp_q.size()), 64'd0);

    // Reset asserted while stalled in the data phase
    $display("[TB] reset mid-TLP");
    feedModelWords(8, 32'hE000_0300);
    expectTransfer(32'h4000_0000, 8, 16'h0108);
    applyStimulus(32'h4000_0000, 16'd8);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!(!trn_tsrc_rdy_n && !trn_tsof_n) && n < 100);
    checkOutput("rst_mid_sof_seen", 64'(n < 100), 64'd1);
    @(posedge clk); #1;
    @(posedge clk); #1;
    trn_tdst_rdy_n = 1'b1;
    @(negedge clk);
    checkOutput("rst_mid_active", 64'(trn_tsrc_rdy_n), 64'd0);
    #2;
    trn_reset_n = 1'b0;
    feed_q.delete();
    model_q.delete();
    exp_q.delete();
    #1;
    checkOutput("rst_mid_srdy", 64'(trn_tsrc_rdy_n), 64'd1);
    checkOutput("rst_mid_sof_eof", {62'd0, trn_tsof_n, trn_teof_n}, 64'd3);
    checkOutput("rst_mid_trem", 64'(trn_trem_n), 64'd0);
    checkOutput("rst_mid_td", trn_td, 64'd0);
    checkOutput("rst_mid_busy", 64'(busy), 64'd0);
    checkOutput("rst_mid_done", 64'(done), 64'd0);
    checkOutput("rst_mid_ready", 64'(data_ready), 64'd1);
    trn_tdst_rdy_n = 1'b0;
    repeat (2) @(posedge clk);
    #1 trn_reset_n = 1'b1;

    // Recovery after reset
    $display("[TB] recovery");
    feedModelWords(3, 32'hF000_0400);
    expectTransfer(32'h8000_0010, 3, 16'h0108);
    d0 = done_count;
    applyStimulus(32'h8000_0010, 16'd3);
    endOfTransfer("recover", 100, d0);

    $display("%0d/%0d checks passed", pass_count, check_count);
    $finish;
  end

endmodule
